video_mnist_cnn_frame_ctl: RTL and testbench

- Frame-level run/stop controller placed between the video source and the MNIST CNN core input stream.
- Admits whole frames only, starting at a start-of-frame beat (tuser[0]=1) and stopping at a frame boundary.
- Drops beats while stopped, without stalling upstream.
- Drives param_blank_num to the core from a shadow register that is updated only at a frame boundary, and reports measured frame geometry and frame count.

---
 rtl/video_mnist_cnn_frame_ctl.sv | 183 ++++++++++++++++++
 tb/tb_video_mnist_cnn_frame_ctl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mnist_cnn_frame_ctl.sv
// Frame-granular run/stop gate in front of the MNIST CNN core; one registered output stage, 1-cycle latency.
// Passed beats stall on m_axi4s_tready; dropped beats are always accepted so upstream never stalls while stopped.
module video_mnist_cnn_frame_ctl #(
    parameter int TUSER_WIDTH     = 1,
    parameter int TDATA_WIDTH     = 1,
    parameter int IMG_X_WIDTH     = 11,
    parameter int IMG_Y_WIDTH     = 10,
    parameter int BLANK_Y_WIDTH   = 8,
    parameter int INIT_BLANK_NUM  = 0,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ctl_enable,
    input  logic                       ctl_update,
    input  logic [BLANK_Y_WIDTH-1:0]   ctl_blank_num,
    output logic [BLANK_Y_WIDTH-1:0]   param_blank_num,
    output logic                       status_busy,
    output logic                       status_update_pending,
    output logic [FRAME_CNT_WIDTH-1:0] status_frame_count,
    output logic [IMG_X_WIDTH-1:0]     status_width,
    output logic [IMG_Y_WIDTH-1:0]     status_height,
    input  logic [TUSER_WIDTH-1:0]     s_axi4s_tuser,
    input  logic                       s_axi4s_tlast,
    input  logic [TDATA_WIDTH-1:0]     s_axi4s_tdata,
    input  logic                       s_axi4s_tvalid,
    output logic                       s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]     m_axi4s_tuser,
    output logic                       m_axi4s_tlast,
    output logic [TDATA_WIDTH-1:0]     m_axi4s_tdata,
    output logic                       m_axi4s_tvalid,
    input  logic                       m_axi4s_tready
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [TUSER_WIDTH-1:0] user;
        logic                   last;
        logic [TDATA_WIDTH-1:0] data;
    } beat_t;

    function automatic logic [IMG_X_WIDTH-1:0] sat_inc_x(input logic [IMG_X_WIDTH-1:0] v);
        return (&v) ? v : v + IMG_X_WIDTH'(1);
    endfunction

    function automatic logic [IMG_Y_WIDTH-1:0] sat_inc_y(input logic [IMG_Y_WIDTH-1:0] v);
        return (&v) ? v : v + IMG_Y_WIDTH'(1);
    endfunction

    state_e                     state_q, state_d;
    beat_t                      m_beat_q, m_beat_d;
    logic                       m_vld_q, m_vld_d;
    logic [BLANK_Y_WIDTH-1:0]   shadow_q, shadow_d;
    logic [BLANK_Y_WIDTH-1:0]   param_q, param_d;
    logic                       pend_q, pend_d;
    logic [IMG_X_WIDTH-1:0]     x_q, x_d;
    logic [IMG_Y_WIDTH-1:0]     y_q, y_d;
    logic [IMG_X_WIDTH-1:0]     width_q, width_d;
    logic [IMG_Y_WIDTH-1:0]     height_q, height_d;
    logic [FRAME_CNT_WIDTH-1:0] fcnt_q, fcnt_d;

    logic                       sof;
    logic                       pass;
    logic                       s_rdy;
    logic                       acc;
    logic                       acc_pass;
    logic                       acc_sof;
    logic [IMG_X_WIDTH-1:0]     x_pos;

    // In RUN only a disabled SOF is refused; in IDLE only an enabled SOF gets in.
    assign sof      = s_axi4s_tuser[0];
    assign pass     = (state_q == ST_RUN) ? !(sof && !ctl_enable) : (sof && ctl_enable);
    assign s_rdy    = pass ? (!m_vld_q || m_axi4s_tready) : 1'b1;
    assign acc      = s_axi4s_tvalid && s_rdy;
    assign acc_pass = acc && pass;
    assign acc_sof  = acc_pass && sof;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (acc_sof) state_d = ST_RUN;
            ST_RUN:  if (acc && sof && !ctl_enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_vld_d  = m_vld_q;
        m_beat_d = m_beat_q;
        if (acc_pass) begin
            m_vld_d       = 1'b1;
            m_beat_d.user = s_axi4s_tuser;
            m_beat_d.last = s_axi4s_tlast;
            m_beat_d.data = s_axi4s_tdata;
        end else if (m_axi4s_tready) begin
            m_vld_d = 1'b0;
        end
    end

    // A request arriving with the applying SOF stays pending: the SOF takes the old shadow.
    always_comb begin
        shadow_d = shadow_q;
        param_d  = param_q;
        pend_d   = pend_q;
        if (acc_sof && pend_q) begin
            param_d = shadow_q;
            pend_d  = 1'b0;
        end
        if (ctl_update) begin
            shadow_d = ctl_blank_num;
            pend_d   = 1'b1;
        end
    end

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        width_d  = width_q;
        height_d = height_q;
        fcnt_d   = fcnt_q;
        x_pos    = sof ? '0 : x_q;
        if (acc_pass) begin
            if (s_axi4s_tlast) begin
                width_d = sat_inc_x(x_pos);
                x_d     = '0;
            end else begin
                x_d = sat_inc_x(x_pos);
            end
            if (sof) begin
                if (state_q == ST_RUN) height_d = y_q;
                y_d    = s_axi4s_tlast ? IMG_Y_WIDTH'(1) : '0;
                fcnt_d = fcnt_q + FRAME_CNT_WIDTH'(1);
            end else if (s_axi4s_tlast) begin
                y_d = sat_inc_y(y_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            m_vld_q  <= 1'b0;
            m_beat_q <= '0;
            shadow_q <= BLANK_Y_WIDTH'(INIT_BLANK_NUM);
            param_q  <= BLANK_Y_WIDTH'(INIT_BLANK_NUM);
            pend_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            width_q  <= '0;
            height_q <= '0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            m_vld_q  <= m_vld_d;
            m_beat_q <= m_beat_d;
            shadow_q <= shadow_d;
            param_q  <= param_d;
            pend_q   <= pend_d;
            x_q      <= x_d;
            y_q      <= y_d;
            width_q  <= width_d;
            height_q <= height_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign s_axi4s_tready        = s_rdy;
    assign m_axi4s_tvalid        = m_vld_q;
    assign m_axi4s_tuser         = m_beat_q.user;
    assign m_axi4s_tlast         = m_beat_q.last;
    assign m_axi4s_tdata         = m_beat_q.data;
    assign param_blank_num       = param_q;
    assign status_busy           = (state_q == ST_RUN);
    assign status_update_pending = pend_q;
    assign status_frame_count    = fcnt_q;
    assign status_width          = width_q;
    assign status_height         = height_q;

endmodule

// File: tb/tb_video_mnist_cnn_frame_ctl.sv
// Directed bench for video_mnist_cnn_frame_ctl: 4x3 frames with data = base + beat index,
// hand-computed expectations plus an in-order queue of the beats that should reach the core.
module tb_video_mnist_cnn_frame_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctl_enable;
    logic        ctl_update;
    logic [7:0]  ctl_blank_num;
    logic [7:0]  param_blank_num;
    logic        status_busy;
    logic        status_update_pending;
    logic [15:0] status_frame_count;
    logic [10:0] status_width;
    logic [9:0]  status_height;
    logic [0:0]  s_tuser;
    logic        s_tlast;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [0:0]  m_tuser;
    logic        m_tlast;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    video_mnist_cnn_frame_ctl #(
        .TDATA_WIDTH(8)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ctl_enable            (ctl_enable),
        .ctl_update            (ctl_update),
        .ctl_blank_num         (ctl_blank_num),
        .param_blank_num       (param_blank_num),
        .status_busy           (status_busy),
        .status_update_pending (status_update_pending),
        .status_frame_count    (status_frame_count),
        .status_width          (status_width),
        .status_height         (status_height),
        .s_axi4s_tuser         (s_tuser),
        .s_axi4s_tlast         (s_tlast),
        .s_axi4s_tdata         (s_tdata),
        .s_axi4s_tvalid        (s_tvalid),
        .s_axi4s_tready        (s_tready),
        .m_axi4s_tuser         (m_tuser),
        .m_axi4s_tlast         (m_tlast),
        .m_axi4s_tdata         (m_tdata),
        .m_axi4s_tvalid        (m_tvalid),
        .m_axi4s_tready        (m_tready)
    );

    // Inputs only change just after a rising edge, so the falling edge sees the handshake that the next edge completes.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) got_q.push_back(m_tdata);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input int idx, input logic [7:0] base, input logic exp_pass);
        logic [7:0] d;
        d        = base + 8'(idx);
        s_tvalid = 1'b1;
        s_tuser  = (idx == 0);
        s_tlast  = (idx % 4 == 3);
        s_tdata  = d;
        #1;
        chk("s_tready", 32'(s_tready), 32'd1);
        @(posedge clk); #1;
        ctl_update = 1'b0;
        chk("m_tvalid", 32'(m_tvalid), 32'(exp_pass));
        if (exp_pass) begin
            chk("m_tdata", 32'(m_tdata), 32'(d));
            chk("m_tuser", 32'(m_tuser), 32'(idx == 0));
            chk("m_tlast", 32'(m_tlast), 32'(idx % 4 == 3));
            exp_q.push_back(d);
        end
    endtask

    task automatic stall(input int idx, input logic [7:0] base);
        logic [7:0] d;
        logic [7:0] prev;
        d        = base + 8'(idx);
        prev     = base + 8'(idx - 1);
        s_tvalid = 1'b1;
        s_tuser  = 1'b0;
        s_tlast  = (idx % 4 == 3);
        s_tdata  = d;
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_s_tready", 32'(s_tready), 32'd0);
            chk("stall_m_tvalid", 32'(m_tvalid), 32'd1);
            chk("stall_m_tdata", 32'(m_tdata), 32'(prev));
            @(posedge clk); #1;
        end
        m_tready = 1'b1;
        #1;
        chk("release_s_tready", 32'(s_tready), 32'd1);
        @(posedge clk); #1;
        chk("release_m_tvalid", 32'(m_tvalid), 32'd1);
        chk("release_m_tdata", 32'(m_tdata), 32'(d));
        exp_q.push_back(d);
    endtask

    task automatic frame(input logic [7:0] base, input logic exp_pass, input int first, input int last,
                         input int stall_at, input int upd_at, input logic [7:0] upd_val);
        for (int i = first; i <= last; i++) begin
            if (i == upd_at) begin
                ctl_update    = 1'b1;
                ctl_blank_num = upd_val;
            end
            if (i == stall_at) stall(i, base);
            else beat(i, base, exp_pass);
        end
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string tag);
        idle(2);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_order"}, 32'(got_q[i]), 32'(exp_q[i]));
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        reset         = 1'b1;
        ctl_enable    = 1'b0;
        ctl_update    = 1'b0;
        ctl_blank_num = 8'h00;
        s_tuser       = 1'b0;
        s_tlast       = 1'b0;
        s_tdata       = 8'h00;
        s_tvalid      = 1'b0;
        m_tready      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_busy", 32'(status_busy), 32'd0);
        chk("rst_param", 32'(param_blank_num), 32'd0);
        chk("rst_pending", 32'(status_update_pending), 32'd0);
        chk("rst_fcnt", 32'(status_frame_count), 32'd0);
        chk("rst_width", 32'(status_width), 32'd0);
        chk("rst_height", 32'(status_height), 32'd0);
        reset = 1'b0;
        idle(1);

        // 1: disabled, whole frame dropped without stalling
        frame(8'h00, 1'b0, 0, 11, -1, -1, 8'h00);
        sb_check("t1");
        chk("t1_fcnt", 32'(status_frame_count), 32'd0);
        chk("t1_busy", 32'(status_busy), 32'd0);

        // 2: enable rises mid-frame; the remainder is dropped, then two full frames pass
        frame(8'h10, 1'b0, 0, 1, -1, -1, 8'h00);
        ctl_enable = 1'b1;
        frame(8'h10, 1'b0, 2, 11, -1, -1, 8'h00);
        chk("t2_busy_before", 32'(status_busy), 32'd0);
        frame(8'h20, 1'b1, 0, 11, -1, -1, 8'h00);
        chk("t2_height_first", 32'(status_height), 32'd0);
        chk("t2_busy", 32'(status_busy), 32'd1);
        frame(8'h30, 1'b1, 0, 11, -1, -1, 8'h00);
        sb_check("t2");
        chk("t2_fcnt", 32'(status_frame_count), 32'd2);
        chk("t2_width", 32'(status_width), 32'd4);
        chk("t2_height", 32'(status_height), 32'd3);

        // 3: five cycles of downstream backpressure in the middle of a frame
        frame(8'h40, 1'b1, 0, 11, 2, -1, 8'h00);
        sb_check("t3");
        chk("t3_fcnt", 32'(status_frame_count), 32'd3);
        chk("t3_height", 32'(status_height), 32'd3);

        // 4: blank-count update requested mid-frame, applied by the next SOF
        frame(8'h50, 1'b1, 0, 11, -1, 5, 8'h10);
        chk("t4_param_held", 32'(param_blank_num), 32'd0);
        chk("t4_pending", 32'(status_update_pending), 32'd1);
        frame(8'h60, 1'b1, 0, 0, -1, -1, 8'h00);
        chk("t4_param_applied", 32'(param_blank_num), 32'h10);
        chk("t4_pending_clr", 32'(status_update_pending), 32'd0);
        frame(8'h60, 1'b1, 1, 11, -1, -1, 8'h00);
        sb_check("t4");
        chk("t4_fcnt", 32'(status_frame_count), 32'd5);

        // 5: enable falls mid-frame; that frame completes, the next one is dropped
        frame(8'h70, 1'b1, 0, 5, -1, -1, 8'h00);
        ctl_enable = 1'b0;
        frame(8'h70, 1'b1, 6, 11, -1, -1, 8'h00);
        chk("t5_busy_tail", 32'(status_busy), 32'd1);
        frame(8'h80, 1'b0, 0, 0, -1, -1, 8'h00);
        chk("t5_busy_stop", 32'(status_busy), 32'd0);
        frame(8'h80, 1'b0, 1, 11, -1, -1, 8'h00);
        sb_check("t5");
        chk("t5_fcnt", 32'(status_frame_count), 32'd6);

        // 6: reset while an output beat is held mid-frame
        ctl_enable = 1'b1;
        frame(8'h90, 1'b1, 0, 4, -1, -1, 8'h00);
        chk("t6_pre_m_tvalid", 32'(m_tvalid), 32'd1);
        reset    = 1'b1;
        s_tvalid = 1'b0;
        @(posedge clk); #1;
        chk("t6_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("t6_rst_busy", 32'(status_busy), 32'd0);
        chk("t6_rst_fcnt", 32'(status_frame_count), 32'd0);
        chk("t6_rst_param", 32'(param_blank_num), 32'd0);
        reset = 1'b0;
        sb_check("t6_pre");
        frame(8'h90, 1'b0, 5, 11, -1, -1, 8'h00);
        chk("t6_idle_fcnt", 32'(status_frame_count), 32'd0);
        frame(8'hA0, 1'b1, 0, 11, -1, -1, 8'h00);
        sb_check("t6");
        chk("t6_fcnt", 32'(status_frame_count), 32'd1);
        chk("t6_width", 32'(status_width), 32'd4);
        chk("t6_height", 32'(status_height), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
